io_channel_sequencer: RTL and testbench

//  Parametrised successor to the slow/fast I/O command decode: selects one of N_CH peripheral

---
 rtl/io_channel_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_io_channel_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_channel_sequencer.sv
// Peripheral channel sequencer: selects one channel from a command code, holds its SIGNAL,
// and sends characters as fixed-width PULSEs with ACK handshake, timeout and STOP abort.
module io_channel_sequencer #(
  parameter int N_CH       = 8,
  parameter int CODE_W     = 4,
  parameter int CHAR_W     = 6,
  parameter int SETTLE_CYC = 3,
  parameter int PULSE_CYC  = 4,
  parameter int TMO_W      = 16
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [CODE_W-1:0] CMD_CODE,
  input  logic              CHAR_VALID,
  output logic              CHAR_READY,
  input  logic [CHAR_W-1:0] CHAR_DATA,
  input  logic              CHAR_LAST,
  input  logic              STOP,
  input  logic [N_CH-1:0]   DEV_PERMIT,
  input  logic [N_CH-1:0]   DEV_ACK,
  output logic [N_CH-1:0]   DEV_SIGNAL,
  output logic [N_CH-1:0]   DEV_PULSE,
  output logic [CHAR_W-1:0] DEV_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int CNT_MAX = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  // Last count value before the wait has lasted 2**TMO_W-1 cycles.
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'((2 ** TMO_W) - 2);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_WAIT_CHAR = 3'd2,
    ST_PULSE     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  state_t             state_r;
  logic [N_CH-1:0]    ch_mask_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [TMO_W-1:0]   tmo_r;
  logic               last_r;
  logic               ack_seen_r;
  logic               abort_pend_r;

  logic [N_CH-1:0]    cmd_mask_s;
  logic               cmd_ok_s;
  logic               cmd_fire_s;
  logic               char_fire_s;
  logic               ack_s;
  logic               abort_s;

  // Codes at or above N_CH decode to an all-zero mask and so fail the permit test.
  function automatic logic [N_CH-1:0] code_onehot(input logic [CODE_W-1:0] code);
    logic [N_CH-1:0] v;
    v = '0;
    for (int i = 0; i < N_CH; i++) begin
      v[i] = (code == CODE_W'(i));
    end
    return v;
  endfunction

  assign cmd_mask_s  = code_onehot(CMD_CODE);
  assign cmd_ok_s    = |(cmd_mask_s & DEV_PERMIT);
  assign cmd_fire_s  = CMD_VALID & CMD_READY;
  assign char_fire_s = CHAR_VALID & CHAR_READY;
  assign ack_s       = |(DEV_ACK & ch_mask_r);
  // Losing permit on the selected channel behaves exactly like STOP.
  assign abort_s     = STOP | ~(|(DEV_PERMIT & ch_mask_r));

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      CMD_READY    <= 1'b1;
      CHAR_READY   <= 1'b0;
      DEV_SIGNAL   <= '0;
      DEV_PULSE    <= '0;
      DEV_DATA     <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
      ch_mask_r    <= '0;
      cnt_r        <= '0;
      tmo_r        <= '0;
      last_r       <= 1'b0;
      ack_seen_r   <= 1'b0;
      abort_pend_r <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            if (cmd_ok_s) begin
              ch_mask_r    <= cmd_mask_s;
              DEV_SIGNAL   <= cmd_mask_s;
              CMD_READY    <= 1'b0;
              BUSY         <= 1'b1;
              cnt_r        <= '0;
              abort_pend_r <= 1'b0;
              state_r      <= ST_SETTLE;
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (abort_s) begin
            DEV_SIGNAL <= '0;
            ERR        <= 1'b1;
            state_r    <= ST_FINISH;
          end else if (cnt_r == SETTLE_LAST) begin
            CHAR_READY <= 1'b1;
            state_r    <= ST_WAIT_CHAR;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_CHAR: begin
          if (abort_s) begin
            CHAR_READY <= 1'b0;
            DEV_SIGNAL <= '0;
            ERR        <= 1'b1;
            state_r    <= ST_FINISH;
          end else if (char_fire_s) begin
            CHAR_READY <= 1'b0;
            DEV_DATA   <= CHAR_DATA;
            last_r     <= CHAR_LAST;
            DEV_PULSE  <= ch_mask_r;
            cnt_r      <= '0;
            ack_seen_r <= 1'b0;
            state_r    <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          // An early ACK or abort request is remembered until the pulse has run its full width.
          if (ack_s) begin
            ack_seen_r <= 1'b1;
          end
          if (abort_s) begin
            abort_pend_r <= 1'b1;
          end
          if (cnt_r == PULSE_LAST) begin
            DEV_PULSE <= '0;
            tmo_r     <= '0;
            state_r   <= ST_WAIT_ACK;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (ack_s || ack_seen_r) begin
            ack_seen_r <= 1'b0;
            if (abort_pend_r || abort_s) begin
              DEV_SIGNAL <= '0;
              ERR        <= 1'b1;
              state_r    <= ST_FINISH;
            end else if (last_r) begin
              DEV_SIGNAL <= '0;
              DONE       <= 1'b1;
              state_r    <= ST_FINISH;
            end else begin
              CHAR_READY <= 1'b1;
              state_r    <= ST_WAIT_CHAR;
            end
          end else if (tmo_r == TMO_LAST) begin
            DEV_SIGNAL <= '0;
            ERR        <= 1'b1;
            state_r    <= ST_FINISH;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
            if (abort_s) begin
              abort_pend_r <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          CMD_READY <= 1'b1;
          BUSY      <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          CMD_READY  <= 1'b1;
          CHAR_READY <= 1'b0;
          DEV_SIGNAL <= '0;
          DEV_PULSE  <= '0;
          BUSY       <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_channel_sequencer.sv
// Directed bench for io_channel_sequencer: table of command decode vectors plus
// hand-written sequences for block transfer, timeout, STOP, ACK filtering and reset.
module tb_io_channel_sequencer;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       CMD_VALID, CMD_READY;
  logic [3:0] CMD_CODE;
  logic       CHAR_VALID, CHAR_READY;
  logic [5:0] CHAR_DATA;
  logic       CHAR_LAST, STOP;
  logic [7:0] DEV_PERMIT, DEV_ACK, DEV_SIGNAL, DEV_PULSE;
  logic [5:0] DEV_DATA;
  logic       BUSY, DONE, ERR;

  int errors = 0;
  int checks = 0;
  int done_seen = 0, err_seen = 0, viol = 0, watch_bad = 0;
  logic       watch_en = 1'b0;
  logic [7:0] watch_sig = 8'h00;

  io_channel_sequencer #(.N_CH(8), .CODE_W(4), .CHAR_W(6), .SETTLE_CYC(3),
                         .PULSE_CYC(4), .TMO_W(4)) dut (
    .CLK(CLK), .rst_n(rst_n), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_CODE(CMD_CODE), .CHAR_VALID(CHAR_VALID), .CHAR_READY(CHAR_READY),
    .CHAR_DATA(CHAR_DATA), .CHAR_LAST(CHAR_LAST), .STOP(STOP),
    .DEV_PERMIT(DEV_PERMIT), .DEV_ACK(DEV_ACK), .DEV_SIGNAL(DEV_SIGNAL),
    .DEV_PULSE(DEV_PULSE), .DEV_DATA(DEV_DATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR));

  always #5 CLK = ~CLK;

  // Mid-cycle monitor: strobe counts and structural properties of the outputs.
  always @(negedge CLK) begin
    if (rst_n) begin
      if (DONE) done_seen <= done_seen + 1;
      if (ERR) err_seen <= err_seen + 1;
      if (!$onehot0(DEV_SIGNAL) || !$onehot0(DEV_PULSE) ||
          ((DEV_PULSE & ~DEV_SIGNAL) != 8'h00) || (DONE && ERR))
        viol <= viol + 1;
      if (watch_en && (DEV_SIGNAL != watch_sig)) watch_bad <= watch_bad + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] code);
    CMD_CODE  = code;
    CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic send_char(input logic [5:0] d, input logic last);
    CHAR_DATA  = d;
    CHAR_LAST  = last;
    CHAR_VALID = 1'b1;
    tick();
    CHAR_VALID = 1'b0;
  endtask

  // Counts consecutive cycles the pulse equals m; leaves the bench in the first low cycle.
  task automatic pulse_len(input logic [7:0] m, output int hi);
    int n = 0;
    while (DEV_PULSE == m && n < 10) begin
      n++;
      tick();
    end
    hi = n;
  endtask

  typedef struct {
    logic [3:0] code;
    logic [7:0] permit;
    logic       exp_err;
    logic [7:0] exp_sig;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[7];
  logic [5:0] chars[3];

  initial begin
    int hi, d0, e0, wb0;

    vecs[0] = '{code: 4'd8,  permit: 8'hFF, exp_err: 1'b1, exp_sig: 8'h00, exp_busy: 1'b0};
    vecs[1] = '{code: 4'd15, permit: 8'hFF, exp_err: 1'b1, exp_sig: 8'h00, exp_busy: 1'b0};
    vecs[2] = '{code: 4'd1,  permit: 8'hFD, exp_err: 1'b1, exp_sig: 8'h00, exp_busy: 1'b0};
    vecs[3] = '{code: 4'd0,  permit: 8'hFE, exp_err: 1'b1, exp_sig: 8'h00, exp_busy: 1'b0};
    vecs[4] = '{code: 4'd7,  permit: 8'h80, exp_err: 1'b0, exp_sig: 8'h80, exp_busy: 1'b1};
    vecs[5] = '{code: 4'd2,  permit: 8'hFF, exp_err: 1'b0, exp_sig: 8'h04, exp_busy: 1'b1};
    vecs[6] = '{code: 4'd0,  permit: 8'h01, exp_err: 1'b0, exp_sig: 8'h01, exp_busy: 1'b1};
    chars[0] = 6'h15; chars[1] = 6'h2A; chars[2] = 6'h3F;

    rst_n = 1'b0; CMD_VALID = 1'b0; CMD_CODE = 4'd0; CHAR_VALID = 1'b0;
    CHAR_DATA = 6'd0; CHAR_LAST = 1'b0; STOP = 1'b0; DEV_PERMIT = 8'hFF; DEV_ACK = 8'h00;

    #12;
    check("rst_cmd_ready", CMD_READY, 1);
    check("rst_outputs", {CHAR_READY, DEV_SIGNAL, DEV_PULSE, DEV_DATA, BUSY, DONE, ERR}, 0);
    @(negedge CLK) rst_n = 1'b1;
    tick();

    // Command decode table: illegal codes / missing permit vs. legal selects.
    for (int i = 0; i < 7; i++) begin
      DEV_PERMIT = vecs[i].permit;
      send_cmd(vecs[i].code);
      check($sformatf("dec%0d_err", i), ERR, vecs[i].exp_err);
      check($sformatf("dec%0d_sig", i), DEV_SIGNAL, vecs[i].exp_sig);
      check($sformatf("dec%0d_busy", i), BUSY, vecs[i].exp_busy);
      if (vecs[i].exp_busy) begin
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        check($sformatf("dec%0d_abort", i), {ERR, DONE, DEV_SIGNAL}, {2'b10, 8'h00});
      end
      tick();
      check($sformatf("dec%0d_idle", i), {BUSY, CMD_READY, ERR}, 3'b010);
    end
    DEV_PERMIT = 8'hFF;

    // Block of three characters on channel 2, ACK in the 5th cycle after each pulse.
    d0 = done_seen; e0 = err_seen; wb0 = watch_bad;
    send_cmd(4'd2);
    check("t1_select", {DEV_SIGNAL, BUSY, CMD_READY}, {8'h04, 2'b10});
    watch_sig = 8'h04; watch_en = 1'b1;
    repeat (2) tick();
    check("t1_settle_ready", CHAR_READY, 0);
    tick();
    check("t1_char_ready", CHAR_READY, 1);
    for (int k = 0; k < 3; k++) begin
      send_char(chars[k], (k == 2));
      check($sformatf("t1_data%0d", k), DEV_DATA, chars[k]);
      pulse_len(8'h04, hi);
      check($sformatf("t1_width%0d", k), hi, 4);
      repeat (4) tick();
      if (k == 2) watch_en = 1'b0;
      DEV_ACK = 8'h04;
      tick();
      DEV_ACK = 8'h00;
      if (k < 2) check($sformatf("t1_next%0d", k), {CHAR_READY, DONE}, 2'b10);
    end
    check("t1_done", {DONE, ERR, DEV_SIGNAL}, {2'b10, 8'h00});
    tick();
    check("t1_idle", {DONE, BUSY, CMD_READY, DEV_SIGNAL}, {3'b001, 8'h00});
    check("t1_done_count", done_seen - d0, 1);
    check("t1_err_count", err_seen - e0, 0);
    check("t1_signal_held", watch_bad - wb0, 0);

    // Timeout with no ACK: ERR in the 15th cycle after the pulse falls.
    e0 = err_seen;
    send_cmd(4'd3);
    repeat (3) tick();
    send_char(6'h01, 1'b0);
    pulse_len(8'h08, hi);
    check("t3_width", hi, 4);
    repeat (14) tick();
    check("t3_waiting", {BUSY, DEV_SIGNAL}, {1'b1, 8'h08});
    check("t3_no_early_err", err_seen - e0, 0);
    tick();
    check("t3_timeout_err", {ERR, DONE, DEV_SIGNAL}, {2'b10, 8'h00});
    tick();
    check("t3_idle", {BUSY, CMD_READY}, 2'b01);

    // STOP in pulse cycle 2: full pulse, ACK awaited, then ERR even though LAST.
    d0 = done_seen;
    send_cmd(4'd4);
    repeat (3) tick();
    send_char(6'h2A, 1'b1);
    tick();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    check("t4_pulse_p3", DEV_PULSE, 8'h10);
    tick();
    check("t4_pulse_p4", DEV_PULSE, 8'h10);
    tick();
    check("t4_wait_ack", {DEV_PULSE, DEV_SIGNAL, ERR}, {8'h00, 8'h10, 1'b0});
    DEV_ACK = 8'h10;
    tick();
    DEV_ACK = 8'h00;
    check("t4_abort_err", {ERR, DONE, DEV_SIGNAL}, {2'b10, 8'h00});
    tick();
    check("t4_no_done", done_seen - d0, 0);

    // Foreign ACK ignored; ACK during pulse honoured on the first WAIT_ACK cycle.
    send_cmd(4'd5);
    repeat (3) tick();
    send_char(6'h0F, 1'b0);
    pulse_len(8'h20, hi);
    check("t5_width", hi, 4);
    DEV_ACK = 8'h08;
    tick();
    DEV_ACK = 8'h00;
    check("t5_foreign_ack", {CHAR_READY, BUSY, DEV_SIGNAL}, {2'b01, 8'h20});
    DEV_ACK = 8'h20;
    tick();
    DEV_ACK = 8'h00;
    check("t5_own_ack", CHAR_READY, 1);
    send_char(6'h30, 1'b1);
    check("t5_data", DEV_DATA, 6'h30);
    tick();
    DEV_ACK = 8'h20;
    tick();
    DEV_ACK = 8'h00;
    tick();
    check("t5_pulse_kept", DEV_PULSE, 8'h20);
    tick();
    check("t5_wait_ack", {DEV_PULSE, DONE}, 9'h000);
    tick();
    check("t5_early_ack_done", {DONE, ERR, DEV_SIGNAL}, {2'b10, 8'h00});
    tick();

    // Reset asserted while waiting for ACK.
    d0 = done_seen; e0 = err_seen;
    send_cmd(4'd6);
    repeat (3) tick();
    send_char(6'h11, 1'b0);
    pulse_len(8'h40, hi);
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", {DEV_SIGNAL, DEV_PULSE, DEV_DATA, CHAR_READY, BUSY, DONE, ERR}, 0);
    @(negedge CLK) rst_n = 1'b1;
    tick();
    check("t6_after_release", {CMD_READY, BUSY, DEV_SIGNAL}, {2'b10, 8'h00});
    tick();
    check("t6_no_strobes", (done_seen - d0) + (err_seen - e0), 0);
    check("output_properties", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
